// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : router_pkg
//  Description : Shared flit layout for the deflection-router permutation
//                engine. Provides the 32-bit flit type, field positions,
//                the port enumeration and small field-access helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int FLIT_W    = 32;

    // Field positions inside a flit.
    localparam int VALID_BIT = 0;
    localparam int DST_LSB   = 4;
    localparam int DST_W     = 3;
    localparam int SRC_LSB   = 8;
    localparam int SEQ_LSB   = 16;
    localparam int AGE_LSB   = 24;
    localparam int AGE_W     = 8;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        N = 2'd0,
        E = 2'd1,
        S = 2'd2,
        W = 2'd3
    } port_e;

    function automatic logic flit_valid(input flit_t f);
        return f[VALID_BIT];
    endfunction

    function automatic logic [AGE_W-1:0] flit_age(input flit_t f);
        return f[AGE_LSB +: AGE_W];
    endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/golden_pair_arb.sv
`default_nettype none
// ============================================================================
//  Module      : golden_pair_arb
//  Description : Priority decision for one 2x2 arbitration block. Purely
//                combinational. Selects which of the two inputs is
//                prioritised and reports whether the decision fell back to
//                the round-robin tiebreak.
//  Ports       : flit_a_i / flit_b_i   - input 0 / input 1 flits
//                golden_node_i/_seq_i  - current golden packet identity
//                rr_i                  - round-robin tiebreak bit
//                winner_o              - 0: input 0 wins, 1: input 1 wins
//                tie_used_o            - decision was taken from rr_i
//  Options     : OLDEST_FIRST_EN - break ties by larger age before rr_i
//  Revision    : 1.0 - initial release
// ============================================================================
module golden_pair_arb
    import router_pkg::*;
#(
    parameter int NODE_W = 4,
    parameter int SEQ_W  = 4
) (
    input  flit_t             flit_a_i,
    input  flit_t             flit_b_i,
    input  logic [NODE_W-1:0] golden_node_i,
    input  logic [SEQ_W-1:0]  golden_seq_i,
    input  logic              rr_i,
    output logic              winner_o,
    output logic              tie_used_o
);

    logic w_valid_a;
    logic w_valid_b;
    logic w_golden_a;
    logic w_golden_b;
    logic w_unused_bits;

    assign w_valid_a  = flit_valid(flit_a_i);
    assign w_valid_b  = flit_valid(flit_b_i);

    assign w_golden_a = w_valid_a
                     && (flit_a_i[SRC_LSB +: NODE_W] == golden_node_i)
                     && (flit_a_i[SEQ_LSB +: SEQ_W]  == golden_seq_i);
    assign w_golden_b = w_valid_b
                     && (flit_b_i[SRC_LSB +: NODE_W] == golden_node_i)
                     && (flit_b_i[SEQ_LSB +: SEQ_W]  == golden_seq_i);

`ifdef OLDEST_FIRST_EN
    logic w_age_differ;
    logic w_b_older;

    assign w_age_differ = (flit_age(flit_a_i) != flit_age(flit_b_i));
    assign w_b_older    = (flit_age(flit_b_i) >  flit_age(flit_a_i));
`endif

    always_comb begin
        winner_o   = 1'b0;
        tie_used_o = 1'b0;
        if (w_valid_a != w_valid_b) begin
            // Lone valid input always wins.
            winner_o = w_valid_b;
        end else if (!w_valid_a) begin
            winner_o = 1'b0;
        end else if (w_golden_a != w_golden_b) begin
            // Golden flit gets guaranteed progress.
            winner_o = w_golden_b;
`ifdef OLDEST_FIRST_EN
        end else if (w_age_differ) begin
            winner_o = w_b_older;
`endif
        end else begin
            winner_o   = rr_i;
            tie_used_o = 1'b1;
        end
    end

    // Dst, padding and (in the default build) age bits do not affect priority.
    assign w_unused_bits = ^{flit_a_i, flit_b_i};

endmodule : golden_pair_arb
`default_nettype wire

// File: rtl/golden_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : golden_arb_ctrl
//  Description : Priority controller for the four 2x2 arbitration blocks of
//                the deflection-router permutation engine. Holds the
//                network-synchronised golden-packet epoch state and one
//                round-robin tiebreak bit per block, and drives one winner
//                bit per block so every golden flit makes forward progress.
//  Ports       : clk, rst_n        - clock, synchronous active-low reset
//                en                - advance epoch / rr state this cycle
//                blk_flit_a/_b     - per-block input 0/1 flits, block k in
//                                    bits [32k+31:32k]
//                winner            - bit k: 0 input 0 wins, 1 input 1 wins
//                golden_node/_seq  - current golden packet identity
//                epoch_wrap        - pulse in the cycle after an epoch wrap
//  Options     : OLDEST_FIRST_EN - age-based tiebreak before round-robin
//  Revision    : 1.0 - initial release
// ============================================================================
module golden_arb_ctrl
    import router_pkg::*;
#(
    parameter int NUM_NODES = 16,
    parameter int NODE_W    = 4,
    parameter int SEQ_W     = 4,
    parameter int EPOCH_LEN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*FLIT_W-1:0] blk_flit_a,
    input  logic [4*FLIT_W-1:0] blk_flit_b,
    output logic [3:0]          winner,
    output logic [NODE_W-1:0]   golden_node,
    output logic [SEQ_W-1:0]    golden_seq,
    output logic                epoch_wrap
);

    localparam int                c_num_blk   = 4;
    localparam int                c_cnt_w     = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(EPOCH_LEN - 1);
    localparam logic [NODE_W-1:0]  c_node_last = NODE_W'(NUM_NODES - 1);

    logic [c_cnt_w-1:0]   epoch_cnt_q, epoch_cnt_d;
    logic [NODE_W-1:0]    node_q, node_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic                 wrap_q, wrap_d;
    logic [c_num_blk-1:0] rr_q, rr_d;

    logic [c_num_blk-1:0] w_winner;
    logic [c_num_blk-1:0] w_tie;

    // ------------------------------------------------------------------
    // Per-block priority decision
    // ------------------------------------------------------------------
    for (genvar k = 0; k < c_num_blk; k++) begin : g_blk
        golden_pair_arb #(
            .NODE_W (NODE_W),
            .SEQ_W  (SEQ_W)
        ) u_arb (
            .flit_a_i      (blk_flit_a[k*FLIT_W +: FLIT_W]),
            .flit_b_i      (blk_flit_b[k*FLIT_W +: FLIT_W]),
            .golden_node_i (node_q),
            .golden_seq_i  (seq_q),
            .rr_i          (rr_q[k]),
            .winner_o      (w_winner[k]),
            .tie_used_o    (w_tie[k])
        );
    end

    // ------------------------------------------------------------------
    // Epoch / golden identity / round-robin next state
    // ------------------------------------------------------------------
    always_comb begin
        epoch_cnt_d = epoch_cnt_q;
        node_d      = node_q;
        seq_d       = seq_q;
        wrap_d      = 1'b0;
        rr_d        = rr_q;
        if (en) begin
            // Only blocks that actually fell back to rr flip their bit.
            rr_d = rr_q ^ w_tie;
            if (epoch_cnt_q == c_cnt_last) begin
                epoch_cnt_d = '0;
                wrap_d      = 1'b1;
                seq_d       = seq_q + 1'b1;   // natural roll from all-ones to 0
                if (&seq_q) begin
                    node_d = (node_q == c_node_last) ? '0 : node_q + 1'b1;
                end
            end else begin
                epoch_cnt_d = epoch_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epoch_cnt_q <= '0;
            node_q      <= '0;
            seq_q       <= '0;
            wrap_q      <= 1'b0;
            rr_q        <= '0;
        end else begin
            epoch_cnt_q <= epoch_cnt_d;
            node_q      <= node_d;
            seq_q       <= seq_d;
            wrap_q      <= wrap_d;
            rr_q        <= rr_d;
        end
    end

    assign winner      = w_winner;
    assign golden_node = node_q;
    assign golden_seq  = seq_q;
    assign epoch_wrap  = wrap_q;

endmodule : golden_arb_ctrl
`default_nettype wire
